// File: rtl/gng_pkg.sv
// Shared constants for the AWGN stage fed by the Gaussian noise generator.
// All sample widths are s<16,11>; sigma is u<16,14>.
package gng_pkg;

    localparam int SIG_W      = 16;
    localparam int SCALE_W    = 16;
    localparam int FRAC_BITS  = 11;
    localparam int SCALE_FRAC = 14;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/gng_noise_fifo.sv
// First-word fall-through FIFO buffering generator samples. Read data is valid
// combinationally whenever the FIFO is not empty.
module gng_noise_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = AW + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign occupancy = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage write port; a push while full is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= do_push_s ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    gng_noise_fifo_chk u_chk (
        .clk  (clk),
        .rstn (rstn),
        .push (push),
        .full (full)
    );

endmodule

// File: rtl/gng_noise_fifo_chk.sv
// Protocol checker for the noise FIFO: a push while full would silently lose a
// noise sample. The credit scheme in the top level makes this unreachable.
module gng_noise_fifo_chk (
    input logic clk,
    input logic rstn,
    input logic push,
    input logic full
);

    property p_no_overflow;
        @(posedge clk) disable iff (!rstn) !(push && full);
    endproperty

    a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/gng_awgn_add.sv
// AWGN channel stage: requests noise from the generator under credit control,
// scales each sample by sigma, adds it to the signal stream and saturates.
module gng_awgn_add
    import gng_pkg::*;
#(
    parameter int SIG_W      = gng_pkg::SIG_W,
    parameter int SCALE_W    = gng_pkg::SCALE_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               noise_ce,
    input  logic               noise_valid,
    input  logic [SIG_W-1:0]   noise_data,
    input  logic [SCALE_W-1:0] scale,
    input  logic               sig_valid,
    output logic               sig_ready,
    input  logic [SIG_W-1:0]   sig_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIG_W-1:0]   out_data,
    output logic               sat_pulse
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PROD_W = SIG_W + SCALE_W + 1;     // s<33,25>
    localparam int NS_W   = PROD_W - SCALE_FRAC;     // s<19,11>
    localparam int SUM_W  = NS_W + 1;
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1'b1) << (SCALE_FRAC - 1);
    localparam logic [SIG_W-1:0] OUT_MAX = {1'b0, {(SIG_W-1){1'b1}}};
    localparam logic [SIG_W-1:0] OUT_MIN = {1'b1, {(SIG_W-1){1'b0}}};

    logic [SIG_W-1:0]         fifo_dout_s;
    logic [CNT_W-1:0]         occupancy_s;
    logic                     empty_s;
    logic                     full_s;
    logic [CNT_W-1:0]         inflight_r;
    logic [CNT_W-1:0]         used_s;
    logic [CNT_W-1:0]         credits_s;
    logic                     ce_next_s;
    logic                     s1_valid_r;
    logic [SIG_W-1:0]         s1_sig_r;
    logic [NS_W-1:0]          s1_ns_r;
    logic                     s1_can_accept_s;
    logic                     s2_can_accept_s;
    logic                     fire_s;
    logic signed [PROD_W-1:0] noise_ext_s;
    logic signed [PROD_W-1:0] scale_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] rnd_s;
    logic [NS_W-1:0]          ns_s;
    logic [SUM_W-1:0]         sum_s;
    logic [SIG_W-1:0]         sat_data_s;
    logic                     sat_flag_s;

    gng_noise_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (SIG_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (noise_valid),
        .din       (noise_data),
        .pop       (fire_s),
        .dout      (fifo_dout_s),
        .occupancy (occupancy_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Handshake: a beat fires only when noise is buffered and stage 1 can move.
    assign s2_can_accept_s = ~out_valid | out_ready;
    assign s1_can_accept_s = ~s1_valid_r | s2_can_accept_s;
    assign sig_ready       = ~empty_s & s1_can_accept_s;
    assign fire_s          = sig_valid & sig_ready;

    // Credits count FIFO slots not yet claimed by buffered or requested samples.
    assign used_s    = occupancy_s + inflight_r;
    assign credits_s = CNT_W'(FIFO_DEPTH) - used_s;

    // Next request decision; the request issued this cycle already consumes a credit.
    always_comb begin
        ce_next_s = 1'b0;
        if (full_s) begin
            ce_next_s = 1'b0;
        end else if (credits_s >= CNT_W'(2'd2)) begin
            ce_next_s = 1'b1;
        end else if (credits_s == CNT_W'(1'b1)) begin
            ce_next_s = ~noise_ce;
        end else begin
            ce_next_s = 1'b0;
        end
    end

    // Registered generator enable and count of requested-but-undelivered samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            noise_ce   <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            noise_ce <= ce_next_s;
            case ({noise_ce, noise_valid})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1'b1);
                2'b01:   inflight_r <= (inflight_r != {CNT_W{1'b0}}) ? inflight_r - CNT_W'(1'b1) : inflight_r;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Noise scaling: signed noise times zero-extended sigma, round half up, drop 14 fraction bits.
    always_comb begin
        noise_ext_s = {{(PROD_W-SIG_W){fifo_dout_s[SIG_W-1]}}, fifo_dout_s};
        scale_ext_s = {{(PROD_W-SCALE_W){1'b0}}, scale};
        prod_s      = noise_ext_s * scale_ext_s;
        rnd_s       = prod_s + ROUND_BIAS;
        ns_s        = NS_W'(rnd_s >>> SCALE_FRAC);
    end

    // Stage 1: capture signal and scaled noise on fire, empty when drained, else hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_sig_r   <= {SIG_W{1'b0}};
            s1_ns_r    <= {NS_W{1'b0}};
        end else if (fire_s) begin
            s1_valid_r <= 1'b1;
            s1_sig_r   <= sig_data;
            s1_ns_r    <= ns_s;
        end else if (s2_can_accept_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Sum and clip to the s<16,11> range, flagging saturation.
    always_comb begin
        sum_s      = {{(SUM_W-SIG_W){s1_sig_r[SIG_W-1]}}, s1_sig_r} + {s1_ns_r[NS_W-1], s1_ns_r};
        sat_data_s = sum_s[SIG_W-1:0];
        sat_flag_s = 1'b0;
        if ((sum_s[SUM_W-1:SIG_W-1] == {(SUM_W-SIG_W+1){1'b0}}) ||
            (sum_s[SUM_W-1:SIG_W-1] == {(SUM_W-SIG_W+1){1'b1}})) begin
            sat_flag_s = 1'b0;
        end else if (sum_s[SUM_W-1]) begin
            sat_data_s = OUT_MIN;
            sat_flag_s = 1'b1;
        end else begin
            sat_data_s = OUT_MAX;
            sat_flag_s = 1'b1;
        end
    end

    // Stage 2: output register, held stable while downstream stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= {SIG_W{1'b0}};
            sat_pulse <= 1'b0;
        end else if (s2_can_accept_s) begin
            out_valid <= s1_valid_r;
            sat_pulse <= s1_valid_r & sat_flag_s;
            out_data  <= s1_valid_r ? sat_data_s : out_data;
        end else begin
            out_valid <= out_valid;
            sat_pulse <= sat_pulse;
            out_data  <= out_data;
        end
    end

endmodule
